// File: rtl/assoc_scoreboard.sv
// Open-addressed hash-map scoreboard (cmd_id -> proc_id), linear probing with tombstones.
// Optional ASSOC_SB_MULTI_DEL_EN: DEL_VAL removes every matching slot instead of the first.
module assoc_scoreboard #(
    parameter int DEPTH = 8,
    parameter int KEY_W = 8,
    parameter int VAL_W = 3
) (
    input  logic                       i_clk,
    input  logic                       i_rstn,
    input  logic                       i_req_valid,
    output logic                       o_req_ready,
    input  logic [1:0]                 i_req_op,
    input  logic [KEY_W-1:0]           i_req_key,
    input  logic [VAL_W-1:0]           i_req_val,
    output logic                       o_resp_valid,
    output logic [1:0]                 o_resp_status,
    output logic [VAL_W-1:0]           o_resp_val,
    output logic [$clog2(DEPTH+1)-1:0] o_count,
    output logic                       o_full
);
    localparam int IW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    typedef enum logic [1:0] {OP_INSERT, OP_LOOKUP, OP_DEL_KEY, OP_DEL_VAL} op_t;
    typedef enum logic [1:0] {ST_OK, ST_MISS, ST_FULL, ST_UPDATED} status_t;
    typedef enum logic [1:0] {SL_EMPTY, SL_VALID, SL_TOMB} slot_t;
    typedef enum logic [1:0] {IDLE, PROBE, SCAN, RESP} fsm_t;

    fsm_t             state, state_nxt;
    slot_t            slot_st  [DEPTH];
    logic [KEY_W-1:0] slot_key [DEPTH];
    logic [VAL_W-1:0] slot_val [DEPTH];

    op_t              op_r;
    logic [KEY_W-1:0] key_r;
    logic [VAL_W-1:0] val_r;
    logic [IW-1:0]    step, idx, free_idx, ins_idx;
    logic             free_vld;
    logic [CW-1:0]    count, cnt_nxt;
    status_t          rs, rs_nxt;
    logic [VAL_W-1:0] rv, rv_nxt;
    logic             key_hit, val_hit, is_empty, last, have_free;
    logic             done, ins_wr, upd_wr, tomb_wr, clr_tomb;
`ifdef ASSOC_SB_MULTI_DEL_EN
    logic [CW-1:0]    rm_cnt, rm_total;
`endif

    always_comb begin
        idx       = (state == SCAN) ? step : key_r[IW-1:0] + step;
        key_hit   = (slot_st[idx] == SL_VALID) && (slot_key[idx] == key_r);
        val_hit   = (slot_st[idx] == SL_VALID) && (slot_val[idx] == val_r);
        is_empty  = (slot_st[idx] == SL_EMPTY);
        last      = (step == IW'(DEPTH-1));
        have_free = free_vld || (slot_st[idx] != SL_VALID);
        ins_idx   = free_vld ? free_idx : idx;
    end

    always_comb begin
        state_nxt = state;
        done      = 1'b0;
        ins_wr    = 1'b0;
        upd_wr    = 1'b0;
        tomb_wr   = 1'b0;
        cnt_nxt   = count;
        rs_nxt    = rs;
        rv_nxt    = '0;
`ifdef ASSOC_SB_MULTI_DEL_EN
        rm_total  = rm_cnt + CW'(val_hit);
`endif
        case (state)
            IDLE: if (i_req_valid) state_nxt = (op_t'(i_req_op) == OP_DEL_VAL) ? SCAN : PROBE;
            PROBE: begin
                done = key_hit || is_empty || last;
                if (done) begin
                    state_nxt = RESP;
                    case (op_r)
                        OP_INSERT: begin
                            if (key_hit) begin
                                upd_wr = 1'b1;
                                rs_nxt = ST_UPDATED;
                            end else if (have_free) begin
                                ins_wr  = 1'b1;
                                cnt_nxt = count + CW'(1);
                                rs_nxt  = ST_OK;
                            end else begin
                                rs_nxt = ST_FULL;
                            end
                        end
                        OP_LOOKUP: begin
                            rs_nxt = key_hit ? ST_OK : ST_MISS;
                            if (key_hit) rv_nxt = slot_val[idx];
                        end
                        OP_DEL_KEY: begin
                            rs_nxt = key_hit ? ST_OK : ST_MISS;
                            if (key_hit) begin
                                rv_nxt  = slot_val[idx];
                                tomb_wr = 1'b1;
                                cnt_nxt = count - CW'(1);
                            end
                        end
                        default: rs_nxt = ST_MISS;
                    endcase
                end
            end
            SCAN: begin
                tomb_wr = val_hit;
`ifdef ASSOC_SB_MULTI_DEL_EN
                // Matches are tombstoned as the scan passes; the count settles on the last step.
                done = last;
                if (done) begin
                    state_nxt = RESP;
                    cnt_nxt   = count - rm_total;
                    rs_nxt    = (rm_total != '0) ? ST_OK : ST_MISS;
                    rv_nxt    = VAL_W'(rm_total);
                end
`else
                done = val_hit || last;
                if (done) begin
                    state_nxt = RESP;
                    rs_nxt    = val_hit ? ST_OK : ST_MISS;
                    if (val_hit) begin
                        cnt_nxt = count - CW'(1);
                        rv_nxt  = val_r;
                    end
                end
`endif
            end
            RESP: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        // An empty table needs no tombstones; clearing them keeps probe chains short.
        clr_tomb = done && (cnt_nxt == '0) && (cnt_nxt != count);
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state    <= IDLE;
            op_r     <= OP_INSERT;
            key_r    <= '0;
            val_r    <= '0;
            step     <= '0;
            free_vld <= 1'b0;
            free_idx <= '0;
            count    <= '0;
            rs       <= ST_OK;
            rv       <= '0;
`ifdef ASSOC_SB_MULTI_DEL_EN
            rm_cnt   <= '0;
`endif
            for (int i = 0; i < DEPTH; i++) begin
                slot_st[i]  <= SL_EMPTY;
                slot_key[i] <= '0;
                slot_val[i] <= '0;
            end
        end else begin
            state <= state_nxt;
            count <= cnt_nxt;
            if (state == IDLE && i_req_valid) begin
                op_r     <= op_t'(i_req_op);
                key_r    <= i_req_key;
                val_r    <= i_req_val;
                step     <= '0;
                free_vld <= 1'b0;
`ifdef ASSOC_SB_MULTI_DEL_EN
                rm_cnt   <= '0;
`endif
            end else if (state == PROBE || state == SCAN) begin
                step <= step + IW'(1);
                if (!free_vld && slot_st[idx] != SL_VALID) begin
                    free_vld <= 1'b1;
                    free_idx <= idx;
                end
`ifdef ASSOC_SB_MULTI_DEL_EN
                rm_cnt <= rm_total;
`endif
            end
            if (done) begin
                rs <= rs_nxt;
                rv <= rv_nxt;
            end
            if (upd_wr) slot_val[idx] <= val_r;
            if (ins_wr) begin
                slot_st[ins_idx]  <= SL_VALID;
                slot_key[ins_idx] <= key_r;
                slot_val[ins_idx] <= val_r;
            end
            if (tomb_wr) slot_st[idx] <= SL_TOMB;
            if (clr_tomb) begin
                for (int i = 0; i < DEPTH; i++)
                    if (slot_st[i] == SL_TOMB || (tomb_wr && IW'(i) == idx)) slot_st[i] <= SL_EMPTY;
            end
        end
    end

    assign o_req_ready   = (state == IDLE);
    assign o_resp_valid  = (state == RESP);
    assign o_resp_status = (state == RESP) ? rs : ST_OK;
    assign o_resp_val    = (state == RESP) ? rv : '0;
    assign o_count       = count;
    assign o_full        = (count == CW'(DEPTH));
endmodule
